// File: rtl/demux4_stream.sv
// demux4_stream: 1-to-4 valid/ready stream demux with a 2-entry FIFO per output channel.
// Latency: 1 cycle from accepted input beat to out_valid on the destination channel.
// Backpressure: in_ready = destination FIFO not full (no pop-through); `define DEMUX4_RR_EN steers round-robin.
module demux4_stream #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [4*WIDTH-1:0] out_data,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready
);

  // Per-channel FIFO state and storage
  logic [WIDTH-1:0] mem_q [4][2];
  logic [3:0]       wr_ptr_q, wr_ptr_d;
  logic [3:0]       rd_ptr_q, rd_ptr_d;
  logic [1:0]       cnt_q [4];
  logic [1:0]       cnt_d [4];

  logic [1:0] dest;
  logic       push;
  logic [3:0] push_vec;
  logic [3:0] pop_vec;

`ifdef DEMUX4_RR_EN
  logic [1:0] rr_ptr_q;
  logic       unused_sel;

  // in_sel has no role in round-robin mode
  assign unused_sel = ^in_sel;
  assign dest       = rr_ptr_q;

  // Round-robin pointer advances only on an accepted beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= 2'd0;
    end else if (push) begin
      rr_ptr_q <= rr_ptr_q + 2'd1;
    end
  end
`else
  assign dest = in_sel;
`endif

  // Ready depends only on the destination fill count, never on in_valid or out_ready
  assign in_ready = (cnt_q[dest] < 2'd2);
  assign push     = in_valid & in_ready;

  // Per-channel output view: valid when non-empty, data is the FIFO head
  always_comb begin
    out_valid = 4'b0000;
    out_data  = '0;
    for (int k = 0; k < 4; k++) begin
      out_valid[k]                 = (cnt_q[k] != 2'd0);
      out_data[k*WIDTH +: WIDTH]   = mem_q[k][rd_ptr_q[k]];
    end
  end

  // Next-state for pointers and fill counts of each channel
  always_comb begin
    push_vec = 4'b0000;
    pop_vec  = 4'b0000;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    for (int k = 0; k < 4; k++) begin
      cnt_d[k]    = cnt_q[k];
      push_vec[k] = push && (dest == 2'(k));
      pop_vec[k]  = out_valid[k] & out_ready[k];
      if (push_vec[k]) wr_ptr_d[k] = ~wr_ptr_q[k];
      if (pop_vec[k])  rd_ptr_d[k] = ~rd_ptr_q[k];
      case ({push_vec[k], pop_vec[k]})
        2'b10:   cnt_d[k] = cnt_q[k] + 2'd1;
        2'b01:   cnt_d[k] = cnt_q[k] - 2'd1;
        default: cnt_d[k] = cnt_q[k];
      endcase
    end
  end

  // Control state: reset discards all buffered beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 4'b0000;
      rd_ptr_q <= 4'b0000;
      for (int k = 0; k < 4; k++) begin
        cnt_q[k] <= 2'd0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int k = 0; k < 4; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  // Data storage is written on push only and deliberately has no reset
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (push_vec[k]) begin
        mem_q[k][wr_ptr_q[k]] <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_demux4_stream.sv
// Directed bench for demux4_stream with hand-computed expectations.
// Inputs change 1ns after the rising edge; outputs are checked a further 1ns later.
// Round-robin scenario is exercised when DEMUX4_RR_EN is defined.
module tb_demux4_stream;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic [W-1:0]   in_data;
  logic [1:0]     in_sel;
  logic           in_valid;
  logic           in_ready;
  logic [4*W-1:0] out_data;
  logic [3:0]     out_valid;
  logic [3:0]     out_ready;

  int checks;
  int errors;

  demux4_stream #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] slice(input int k);
    return out_data[k*W +: W];
  endfunction

  // Advance past the next rising edge, leaving time before inputs change
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_data   = '0;
    in_sel    = 2'd0;
    in_valid  = 1'b0;
    out_ready = 4'b1111;

    // Reset state
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

`ifdef DEMUX4_RR_EN
    // Round robin: 8 beats with in_sel tied 0, idle cycle before the 5th
    in_sel = 2'd0;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        in_valid = 1'b0;
        tick();
        check("rr_idle_valid", 32'(out_valid), 32'd0);
      end
      in_valid = 1'b1;
      in_data  = 8'h10 + 8'(i);
      #1;
      check("rr_in_ready", 32'(in_ready), 32'd1);
      tick();
      check("rr_out_valid", 32'(out_valid), 32'(4'b0001 << (i % 4)));
      check("rr_out_data", 32'(slice(i % 4)), 32'(8'h10 + 8'(i)));
    end
    in_valid = 1'b0;
    tick();
    check("rr_drain", 32'(out_valid), 32'd0);
`else
    // First beat to channel 2
    in_sel   = 2'd2;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    tick();
    in_valid = 1'b0;
    check("t1_out_valid", 32'(out_valid), 32'h4);
    check("t1_slice2", 32'(slice(2)), 32'hA5);
    tick();
    check("t1_drained", 32'(out_valid), 32'h0);

    // Stall channel 1, fill it, then release
    out_ready = 4'b1101;
    in_sel    = 2'd1;
    in_valid  = 1'b1;
    in_data   = 8'h01;
    #1;
    check("t2_rdy_b1", 32'(in_ready), 32'd1);
    tick();
    in_data = 8'h02;
    #1;
    check("t2_rdy_b2", 32'(in_ready), 32'd1);
    tick();
    in_data = 8'h03;
    #1;
    check("t2_rdy_full", 32'(in_ready), 32'd0);
    check("t2_head01", 32'(slice(1)), 32'h01);
    tick();
    check("t2_still_full", 32'(in_ready), 32'd0);
    out_ready = 4'b1111;
    #1;
    check("t2_no_popthru", 32'(in_ready), 32'd0);
    tick();
    check("t2_recover_rdy", 32'(in_ready), 32'd1);
    check("t2_head02", 32'(slice(1)), 32'h02);
    tick();
    in_valid = 1'b0;
    check("t2_head03", 32'(slice(1)), 32'h03);
    check("t2_valid03", 32'(out_valid), 32'h2);
    tick();
    check("t2_drained", 32'(out_valid), 32'h0);

    // Continuous streaming with in_sel cycling 0..3
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_sel  = 2'(i % 4);
      in_data = 8'h20 + 8'(i);
      #1;
      check("t3_in_ready", 32'(in_ready), 32'd1);
      tick();
      check("t3_out_valid", 32'(out_valid), 32'(4'b0001 << (i % 4)));
      check("t3_out_data", 32'(slice(i % 4)), 32'(8'h20 + 8'(i)));
    end
    in_valid = 1'b0;
    tick();
    check("t3_drained", 32'(out_valid), 32'h0);

    // Head-of-line: channel 3 full, switch to channel 0
    out_ready = 4'b0111;
    in_sel    = 2'd3;
    in_valid  = 1'b1;
    in_data   = 8'h31;
    tick();
    in_data = 8'h32;
    tick();
    in_data = 8'h33;
    #1;
    check("t4_stall", 32'(in_ready), 32'd0);
    tick();
    check("t4_hold_valid", 32'(out_valid), 32'h8);
    in_sel  = 2'd0;
    in_data = 8'h40;
    #1;
    check("t4_ch0_rdy", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("t4_both_valid", 32'(out_valid), 32'h9);
    check("t4_slice0", 32'(slice(0)), 32'h40);
    check("t4_slice3", 32'(slice(3)), 32'h31);
    tick();
    check("t4_ch0_drained", 32'(out_valid), 32'h8);
    out_ready = 4'b1111;
    tick();
    check("t4_slice3_2nd", 32'(slice(3)), 32'h32);
    check("t4_ch3_last", 32'(out_valid), 32'h8);
    tick();
    check("t4_all_drained", 32'(out_valid), 32'h0);

    // Asynchronous reset while channels 0 and 2 hold data
    out_ready = 4'b0000;
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    in_data   = 8'h50;
    tick();
    in_sel  = 2'd2;
    in_data = 8'h52;
    tick();
    in_sel  = 2'd2;
    in_data = 8'h53;
    tick();
    in_valid = 1'b0;
    check("t5_before_rst", 32'(out_valid), 32'h5);
    check("t5_full_ch2", 32'(in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_valid", 32'(out_valid), 32'h0);
    check("t5_async_rdy", 32'(in_ready), 32'd1);
    tick();
    rst_n     = 1'b1;
    out_ready = 4'b1111;
    tick();
    check("t5_no_reappear", 32'(out_valid), 32'h0);
    tick();
    check("t5_no_reappear2", 32'(out_valid), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
